dff_pipe: RTL

Parametrised successor to the single D flip-flop: a DEPTH-stage, WIDTH-bit register pipeline with per-stage valid bits and a valid/ready handshake. Empty stages collapse, so a stall at the output back-fills bubbles instead of freezing the whole pipe. It also provides a synchronous flush and an occupancy count. It is the team's generic retiming/delay element between datapath blocks.

---
 rtl/dff_pkg.sv | 23 ++
 rtl/dff_stage.sv | 52 +++++
 rtl/dff_pipe.sv | 109 ++++++++++
 3 files changed

// File: rtl/dff_pkg.sv
// -----------------------------------------------------------------------------
// dff_pkg
// Shared definitions for the dff_pipe register pipeline and its stage cell.
//   clog2_cnt()   : width of an occupancy counter able to hold 0..depth
//   DFF_DEF_*     : default WIDTH / DEPTH for dff_pipe
//   dff_hs_t      : one valid/ready handshake pair
// -----------------------------------------------------------------------------
package dff_pkg;

    localparam int unsigned DFF_DEF_WIDTH = 8;
    localparam int unsigned DFF_DEF_DEPTH = 3;

    typedef struct packed {
        logic valid;
        logic ready;
    } dff_hs_t;

    // Bits needed to represent the values 0..depth inclusive.
    function automatic int unsigned clog2_cnt(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_stage.sv
// -----------------------------------------------------------------------------
// dff_stage
// One pipeline slot: a valid bit plus a WIDTH-bit data register.
// The slot loads from upstream when adv=1, holds when adv=0, and drops its
// valid bit on flush.
// Optional build macro DFF_PIPE_CLR_DATA_EN: when defined, flush also loads
// RST_VAL into the data register; otherwise flush leaves the data untouched.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous, active-low reset
//   flush    in   synchronous clear of the valid bit
//   adv      in   slot may take the upstream word this edge
//   d_valid  in   upstream valid
//   d_data   in   upstream data
//   valid    out  slot holds a word
//   data     out  slot data
// -----------------------------------------------------------------------------
module dff_stage #(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             adv,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // NOTE: sequential state is written only with non-blocking assignments so
    // every slot samples its neighbour's pre-edge value.
    // NOTE: the data register is reset as well as the valid bit, so out_data
    // shows a known RST_VAL straight out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            data  <= RST_VAL;
        end else if (flush) begin
            valid <= 1'b0;
`ifdef DFF_PIPE_CLR_DATA_EN
            data  <= RST_VAL;
`endif
        end else if (adv) begin
            valid <= d_valid;
            data  <= d_data;
        end
    end

endmodule

// File: rtl/dff_pipe.sv
// -----------------------------------------------------------------------------
// dff_pipe
// DEPTH-stage, WIDTH-bit register pipeline with per-stage valid bits and a
// valid/ready handshake. Empty stages collapse: a stage advances whenever any
// stage at or beyond it is empty or the output is being consumed, so a stall
// at the output back-fills bubbles instead of freezing the pipe.
// Optional build macro DFF_PIPE_CLR_DATA_EN: flush also clears data registers.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-low reset
//   flush      in   synchronous clear of all valid bits (drops same-cycle input)
//   in_valid   in   upstream word present
//   in_data    in   upstream word
//   in_ready   out  pipe accepts in_data this cycle
//   out_valid  out  last stage holds a word
//   out_data   out  last stage data
//   out_ready  in   downstream accepts out_data
//   count      out  number of valid stages (registered-derived)
// -----------------------------------------------------------------------------
module dff_pipe
    import dff_pkg::*;
#(
    parameter int unsigned      WIDTH   = DFF_DEF_WIDTH,
    parameter int unsigned      DEPTH   = DFF_DEF_DEPTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         out_ready,
    output logic [clog2_cnt(DEPTH)-1:0]  count
);

    localparam int unsigned CW = clog2_cnt(DEPTH);

    if (DEPTH < 1) begin : g_bad_depth
        $error("dff_pipe: DEPTH must be at least 1");
    end

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] adv;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic             bubble;
    dff_hs_t          out_hs;

    assign out_hs = '{valid: valid_q[DEPTH-1], ready: out_ready};

    // Ready chain, walked from the output back to stage 0. adv[i] is true when
    // the output is draining or any stage from i onwards is empty.
    // NOTE: inside always_comb the running 'bubble' uses blocking assignments
    // on purpose, each iteration must see the previous iteration's value.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        adv    = '0;
        bubble = out_hs.ready;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            bubble = bubble | ~valid_q[i];
            adv[i] = bubble;
        end
    end

    assign in_ready = adv[0] & ~flush & rst;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             s_valid;
        logic [WIDTH-1:0] s_data;

        if (i == 0) begin : g_head
            assign s_valid = in_valid & in_ready;
            assign s_data  = in_data;
        end else begin : g_body
            assign s_valid = valid_q[i-1];
            assign s_data  = data_q[i-1];
        end

        dff_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .flush   (flush),
            .adv     (adv[i]),
            .d_valid (s_valid),
            .d_data  (s_data),
            .valid   (valid_q[i]),
            .data    (data_q[i])
        );
    end

    // Popcount of the registered valid bits only.
    always_comb begin
        count = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            count = count + CW'(valid_q[i]);
        end
    end

    assign out_valid = out_hs.valid;
    assign out_data  = data_q[DEPTH-1];

endmodule
